// File: rtl/mem_access_pkg.sv
// Shared RV32I types for the MEM stage: data word, control word, funct3 encodings and MEM FSM states.
package mem_access_pkg;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    PCMUX_PC_PLUS4 = 2'b00,
    PCMUX_ALU_OUT  = 2'b01,
    PCMUX_ALU_MOD2 = 2'b10
  } pcmux_sel_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_read;
    logic       mem_write;
    logic       load_regfile;
    logic [4:0] rd;
    pcmux_sel_t pcmux_sel;
    logic [2:0] regfilemux_sel;
  } rv32i_control_word;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t ST_IDLE  = 2'd0;
  localparam mem_state_t ST_WAIT  = 2'd1;
  localparam mem_state_t ST_DRAIN = 2'd2;

  // funct3[1:0] encodes the access size for both loads and stores
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

endpackage

// File: rtl/mem_access_align.sv
// Byte-enable and store-lane alignment for data cache accesses (purely combinational).
module mem_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  rv32i_word   rs2,
  output logic [3:0]  mbe,
  output rv32i_word   wdata
);

  always_comb begin
    mbe   = 4'b1111;
    wdata = rs2;
    case (size)
      SIZE_BYTE: begin
        mbe   = 4'b0001 << addr_lo;
        wdata = rs2 << {addr_lo, 3'b000};
      end
      SIZE_HALF: begin
        // a halfword at offset 3 would straddle the word; fold it into the upper lanes
        if (addr_lo == 2'd3) begin
          mbe   = 4'b1100;
          wdata = rs2 << 16;
        end else begin
          mbe   = 4'b0011 << addr_lo;
          wdata = rs2 << {addr_lo, 3'b000};
        end
      end
      default: begin
        mbe   = 4'b1111;
        wdata = rs2;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: data cache request FSM plus the MEM/WB register.
// Optional stall-cycle counter enabled by defining MEM_PERF_CNT_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  rv32i_word         ex_pc,
  input  rv32i_word         ex_pc_plus4,
  input  rv32i_word         ex_instruction,
  input  rv32i_control_word ex_ctrl_word,
  input  rv32i_word         ex_alu_out,
  input  rv32i_word         ex_rs2_out,
  input  rv32i_word         ex_br_en,
  input  logic              flush,
  output logic              mem_stall,
  output logic              data_read,
  output logic              data_write,
  output rv32i_word         data_addr,
  output logic [3:0]        data_mbe,
  output rv32i_word         data_wdata,
  input  logic              data_resp,
  input  rv32i_word         data_rdata,
  output logic              wb_valid,
  output rv32i_word         wb_pc,
  output rv32i_word         wb_pc_plus4,
  output rv32i_word         wb_instruction,
  output rv32i_control_word wb_ctrl_word,
  output logic [3:0]        wb_mem_byte_enable,
  output rv32i_word         wb_r_data,
  output rv32i_word         wb_alu,
  output rv32i_word         wb_br_en
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  mem_state_t        state_q, state_d;
  logic              data_read_q, data_read_d;
  logic              data_write_q, data_write_d;
  rv32i_word         data_addr_q, data_addr_d;
  logic [3:0]        data_mbe_q, data_mbe_d;
  rv32i_word         data_wdata_q, data_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  rv32i_word         wb_pc_q, wb_pc_d;
  rv32i_word         wb_pc_plus4_q, wb_pc_plus4_d;
  rv32i_word         wb_instruction_q, wb_instruction_d;
  rv32i_control_word wb_ctrl_q, wb_ctrl_d;
  logic [3:0]        wb_mbe_q, wb_mbe_d;
  rv32i_word         wb_r_data_q, wb_r_data_d;
  rv32i_word         wb_alu_q, wb_alu_d;
  rv32i_word         wb_br_en_q, wb_br_en_d;

  logic       mem_op;
  logic       load_wb;
  rv32i_word  r_data_sel;
  logic [3:0] align_mbe;
  rv32i_word  align_wdata;

  assign mem_op = ex_valid & (ex_ctrl_word.mem_read | ex_ctrl_word.mem_write);

  mem_align u_align (
    .size    (ex_ctrl_word.funct3[1:0]),
    .addr_lo (ex_alu_out[1:0]),
    .rs2     (ex_rs2_out),
    .mbe     (align_mbe),
    .wdata   (align_wdata)
  );

  always_comb begin
    state_d      = state_q;
    data_read_d  = data_read_q;
    data_write_d = data_write_q;
    data_addr_d  = data_addr_q;
    data_mbe_d   = data_mbe_q;
    data_wdata_d = data_wdata_q;
    mem_stall    = 1'b0;
    load_wb      = 1'b0;
    r_data_sel   = '0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !flush) begin
          state_d      = ST_WAIT;
          data_read_d  = ex_ctrl_word.mem_read;
          data_write_d = ex_ctrl_word.mem_write & ~ex_ctrl_word.mem_read;
          data_addr_d  = {ex_alu_out[31:2], 2'b00};
          data_mbe_d   = align_mbe;
          data_wdata_d = align_wdata;
          mem_stall    = 1'b1;
        end else begin
          load_wb = 1'b1;
        end
      end
      ST_WAIT: begin
        if (data_resp) begin
          state_d      = ST_IDLE;
          data_read_d  = 1'b0;
          data_write_d = 1'b0;
          load_wb      = !flush;
          r_data_sel   = data_rdata;
        end else begin
          mem_stall = 1'b1;
          if (flush) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // the cache cannot abort, so wait out the response and throw it away
        mem_stall = 1'b1;
        if (data_resp) begin
          state_d      = ST_IDLE;
          data_read_d  = 1'b0;
          data_write_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        data_read_d  = 1'b0;
        data_write_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wb_valid_d       = 1'b0;
    wb_ctrl_d        = '0;
    wb_pc_d          = wb_pc_q;
    wb_pc_plus4_d    = wb_pc_plus4_q;
    wb_instruction_d = wb_instruction_q;
    wb_mbe_d         = wb_mbe_q;
    wb_r_data_d      = wb_r_data_q;
    wb_alu_d         = wb_alu_q;
    wb_br_en_d       = wb_br_en_q;
    if (load_wb) begin
      wb_valid_d       = ex_valid & ~flush;
      wb_ctrl_d        = ex_ctrl_word;
      wb_pc_d          = ex_pc;
      wb_pc_plus4_d    = ex_pc_plus4;
      wb_instruction_d = ex_instruction;
      wb_mbe_d         = align_mbe;
      wb_r_data_d      = r_data_sel;
      wb_alu_d         = ex_alu_out;
      wb_br_en_d       = ex_br_en;
      // a killed or empty slot must not write the regfile or redirect the PC
      if (!ex_valid || flush) begin
        wb_ctrl_d.load_regfile = 1'b0;
        wb_ctrl_d.pcmux_sel    = PCMUX_PC_PLUS4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      data_read_q      <= 1'b0;
      data_write_q     <= 1'b0;
      data_addr_q      <= '0;
      data_mbe_q       <= '0;
      data_wdata_q     <= '0;
      wb_valid_q       <= 1'b0;
      wb_pc_q          <= '0;
      wb_pc_plus4_q    <= '0;
      wb_instruction_q <= '0;
      wb_ctrl_q        <= '0;
      wb_mbe_q         <= '0;
      wb_r_data_q      <= '0;
      wb_alu_q         <= '0;
      wb_br_en_q       <= '0;
    end else begin
      state_q          <= state_d;
      data_read_q      <= data_read_d;
      data_write_q     <= data_write_d;
      data_addr_q      <= data_addr_d;
      data_mbe_q       <= data_mbe_d;
      data_wdata_q     <= data_wdata_d;
      wb_valid_q       <= wb_valid_d;
      wb_pc_q          <= wb_pc_d;
      wb_pc_plus4_q    <= wb_pc_plus4_d;
      wb_instruction_q <= wb_instruction_d;
      wb_ctrl_q        <= wb_ctrl_d;
      wb_mbe_q         <= wb_mbe_d;
      wb_r_data_q      <= wb_r_data_d;
      wb_alu_q         <= wb_alu_d;
      wb_br_en_q       <= wb_br_en_d;
    end
  end

  assign data_read          = data_read_q;
  assign data_write         = data_write_q;
  assign data_addr          = data_addr_q;
  assign data_mbe           = data_mbe_q;
  assign data_wdata         = data_wdata_q;
  assign wb_valid           = wb_valid_q;
  assign wb_pc              = wb_pc_q;
  assign wb_pc_plus4        = wb_pc_plus4_q;
  assign wb_instruction     = wb_instruction_q;
  assign wb_ctrl_word       = wb_ctrl_q;
  assign wb_mem_byte_enable = wb_mbe_q;
  assign wb_r_data          = wb_r_data_q;
  assign wb_alu             = wb_alu_q;
  assign wb_br_en           = wb_br_en_q;

`ifdef MEM_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  // performance counter not built
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases followed by a randomized instruction stream.
module tb_mem_access;
  import mem_access_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  rv32i_word         ex_pc, ex_pc_plus4, ex_instruction, ex_alu_out, ex_rs2_out, ex_br_en;
  rv32i_control_word ex_ctrl_word;
  logic              flush;
  logic              mem_stall, data_read, data_write;
  rv32i_word         data_addr, data_wdata;
  logic [3:0]        data_mbe;
  logic              data_resp;
  rv32i_word         data_rdata;
  logic              wb_valid;
  rv32i_word         wb_pc, wb_pc_plus4, wb_instruction, wb_r_data, wb_alu, wb_br_en;
  rv32i_control_word wb_ctrl_word;
  logic [3:0]        wb_mem_byte_enable;
`ifdef MEM_PERF_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access #(.STALL_CNT_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .ex_valid           (ex_valid),
    .ex_pc              (ex_pc),
    .ex_pc_plus4        (ex_pc_plus4),
    .ex_instruction     (ex_instruction),
    .ex_ctrl_word       (ex_ctrl_word),
    .ex_alu_out         (ex_alu_out),
    .ex_rs2_out         (ex_rs2_out),
    .ex_br_en           (ex_br_en),
    .flush              (flush),
    .mem_stall          (mem_stall),
    .data_read          (data_read),
    .data_write         (data_write),
    .data_addr          (data_addr),
    .data_mbe           (data_mbe),
    .data_wdata         (data_wdata),
    .data_resp          (data_resp),
    .data_rdata         (data_rdata),
    .wb_valid           (wb_valid),
    .wb_pc              (wb_pc),
    .wb_pc_plus4        (wb_pc_plus4),
    .wb_instruction     (wb_instruction),
    .wb_ctrl_word       (wb_ctrl_word),
    .wb_mem_byte_enable (wb_mem_byte_enable),
    .wb_r_data          (wb_r_data),
    .wb_alu             (wb_alu),
    .wb_br_en           (wb_br_en)
`ifdef MEM_PERF_CNT_EN
    ,
    .stall_cycles       (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, placed at the address offset but pulled back so it stays inside the word.
  function automatic int ref_size(input logic [2:0] f3);
    logic [1:0] s;
    s = f3[1:0];
    if (s == 2'd0) return 1;
    if (s == 2'd1) return 2;
    return 4;
  endfunction

  function automatic int ref_lane(input logic [2:0] f3, input logic [1:0] a);
    int sz;
    int start;
    sz = ref_size(f3);
    start = (sz == 4) ? 0 : int'(a);
    if (start + sz > 4) start = 4 - sz;
    return start;
  endfunction

  function automatic logic [3:0] ref_mbe(input logic [2:0] f3, input logic [1:0] a);
    int sz;
    sz = ref_size(f3);
    return 4'(((1 << sz) - 1) << ref_lane(f3, a));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rs2);
    return rs2 << (8 * ref_lane(f3, a));
  endfunction

  task automatic set_ex(input logic v, input logic rdop, input logic wrop, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rs2);
    rv32i_control_word c;
    c.opcode         = 7'($urandom);
    c.funct3         = f3;
    c.mem_read       = rdop;
    c.mem_write      = wrop;
    c.load_regfile   = rdop | ~wrop;
    c.rd             = 5'($urandom_range(1, 31));
    c.pcmux_sel      = pcmux_sel_t'($urandom_range(0, 2));
    c.regfilemux_sel = 3'($urandom);
    ex_ctrl_word     = c;
    ex_valid         = v;
    ex_pc            = {$urandom} & 32'hFFFF_FFFC;
    ex_pc_plus4      = ex_pc + 32'd4;
    ex_instruction   = $urandom;
    ex_alu_out       = alu;
    ex_rs2_out       = rs2;
    ex_br_en         = {31'd0, 1'($urandom)};
  endtask

  // One instruction through MEM. fl: -1 no flush, 0 flush in issue cycle, k>=1 flush in k-th response-wait cycle.
  task automatic do_inst(input string nm, input logic v, input logic rdop, input logic wrop, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2, input int lat, input int fl,
                         input logic [31:0] rdata);
    logic        is_mem;
    logic [3:0]  m;
    logic [31:0] wd;
    bit          killed;
    set_ex(v, rdop, wrop, f3, alu, rs2);
    is_mem = v & (rdop | wrop);
    m  = ref_mbe(f3, alu[1:0]);
    wd = ref_wdata(f3, alu[1:0], rs2);
    flush = (fl == 0);
    data_resp = 1'b0;
    @(negedge clk);
    chk({nm, ":stall_issue"}, 32'(mem_stall), 32'(is_mem && fl != 0));
    @(posedge clk); #1;
    if (!is_mem || fl == 0) begin
      killed = !v || fl == 0;
      flush = 1'b0;
      chk({nm, ":wb_valid"}, 32'(wb_valid), 32'(!killed));
      chk({nm, ":no_strobe"}, 32'({data_read, data_write}), 32'd0);
      if (!killed) begin
        chk({nm, ":wb_pc"}, wb_pc, ex_pc);
        chk({nm, ":wb_pc4"}, wb_pc_plus4, ex_pc_plus4);
        chk({nm, ":wb_instr"}, wb_instruction, ex_instruction);
        chk({nm, ":wb_alu"}, wb_alu, ex_alu_out);
        chk({nm, ":wb_br"}, wb_br_en, ex_br_en);
        chk({nm, ":wb_ctrl"}, 32'(wb_ctrl_word), 32'(ex_ctrl_word));
      end else begin
        chk({nm, ":bubble_ld"}, 32'(wb_ctrl_word.load_regfile), 32'd0);
        chk({nm, ":bubble_pcmux"}, 32'(wb_ctrl_word.pcmux_sel), 32'(PCMUX_PC_PLUS4));
      end
      return;
    end
    flush = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      data_resp  = (k == lat);
      flush      = (k == fl);
      data_rdata = (k == lat) ? rdata : $urandom;
      @(negedge clk);
      chk({nm, ":data_read"}, 32'(data_read), 32'(rdop));
      chk({nm, ":data_write"}, 32'(data_write), 32'(wrop));
      chk({nm, ":addr"}, data_addr, alu & 32'hFFFF_FFFC);
      chk({nm, ":mbe"}, 32'(data_mbe), 32'(m));
      if (wrop) chk({nm, ":wdata"}, data_wdata, wd);
      chk({nm, ":stall"}, 32'(mem_stall), 32'((k < lat) || (fl >= 1 && fl < k)));
      chk({nm, ":wb_bubble"}, 32'(wb_valid), 32'd0);
      @(posedge clk); #1;
    end
    data_resp = 1'b0;
    flush = 1'b0;
    killed = (fl >= 1);
    chk({nm, ":wb_valid_done"}, 32'(wb_valid), 32'(!killed));
    chk({nm, ":strobe_drop"}, 32'({data_read, data_write}), 32'd0);
    if (!killed) begin
      chk({nm, ":wb_pc"}, wb_pc, ex_pc);
      chk({nm, ":wb_ctrl"}, 32'(wb_ctrl_word), 32'(ex_ctrl_word));
      chk({nm, ":wb_alu"}, wb_alu, ex_alu_out);
      chk({nm, ":wb_mbe"}, 32'(wb_mem_byte_enable), 32'(m));
      chk({nm, ":wb_rdata"}, wb_r_data, rdata);
    end else begin
      chk({nm, ":kill_ld"}, 32'(wb_ctrl_word.load_regfile), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    data_resp = 1'b0;
    data_rdata = '0;
    set_ex(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("reset:data_read", 32'(data_read), 32'd0);
    chk("reset:data_write", 32'(data_write), 32'd0);
    chk("reset:addr", data_addr, 32'd0);
    chk("reset:mbe", 32'(data_mbe), 32'd0);
    chk("reset:wdata", data_wdata, 32'd0);
    chk("reset:wb_valid", 32'(wb_valid), 32'd0);
    chk("reset:wb_ctrl", 32'(wb_ctrl_word), 32'd0);
    chk("reset:wb_rdata", wb_r_data, 32'd0);
    chk("reset:stall", 32'(mem_stall), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    do_inst("lw_0x100", 1'b1, 1'b1, 1'b0, 3'b010, 32'h100, $urandom, 3, -1, 32'hDEAD_BEEF);
    do_inst("after_lw", 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1, -1, 32'h0);
    do_inst("sb_0x203", 1'b1, 1'b0, 1'b1, 3'b000, 32'h203, 32'h0000_00AB, 1, -1, 32'h0);
    do_inst("sh_0x102", 1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_1234, 2, -1, 32'h0);
    do_inst("sh_0x103", 1'b1, 1'b0, 1'b1, 3'b001, 32'h103, 32'h0000_5678, 1, -1, 32'h0);
    do_inst("lh_0x101", 1'b1, 1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 2, -1, 32'h1122_3344);
    chk("const:lh_mbe", 32'(wb_mem_byte_enable), 32'h6);
    for (int i = 0; i < 4; i++)
      do_inst("add", 1'b1, 1'b0, 1'b0, 3'b000, $urandom, $urandom, 1, -1, 32'h0);
    do_inst("lw_drain", 1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 3, 1, 32'h5555_AAAA);
    do_inst("lw_flush_resp", 1'b1, 1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 2, 2, 32'h1234_5678);
    do_inst("lw_flush_issue", 1'b1, 1'b1, 1'b0, 3'b010, 32'h48, 32'h0, 1, 0, 32'h0);
    do_inst("sw_flush_wait", 1'b1, 1'b0, 1'b1, 3'b010, 32'h4C, 32'hCAFE_F00D, 4, 2, 32'h0);

    // asynchronous reset while a load is waiting
    set_ex(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    @(posedge clk); #1;
    chk("rst_mid:strobe_before", 32'(data_read), 32'd1);
    ex_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid:data_read", 32'(data_read), 32'd0);
    chk("rst_mid:data_write", 32'(data_write), 32'd0);
    chk("rst_mid:wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    data_resp = 1'b1;
    data_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    data_resp = 1'b0;
    chk("rst_mid:stray_resp_wb", 32'(wb_valid), 32'd0);
    chk("rst_mid:stray_resp_strobe", 32'(data_read), 32'd0);

    // randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      int          kind;
      int          lat;
      int          fl;
      int          pick;
      logic [2:0]  f3;
      kind = $urandom_range(0, 9);
      lat  = $urandom_range(1, 4);
      fl   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat) : -1;
      if (kind <= 2) begin
        do_inst("r_alu", 1'($urandom_range(0, 7) != 0), 1'b0, 1'b0, 3'($urandom), $urandom, $urandom,
                1, (fl == 0) ? 0 : -1, 32'h0);
      end else if (kind <= 5) begin
        pick = $urandom_range(0, 4);
        f3 = (pick < 3) ? 3'(pick) : 3'(pick + 1);
        do_inst("r_load", 1'b1, 1'b1, 1'b0, f3, $urandom, $urandom, lat, fl, $urandom);
      end else if (kind <= 8) begin
        f3 = 3'($urandom_range(0, 2));
        do_inst("r_store", 1'b1, 1'b0, 1'b1, f3, $urandom, $urandom, lat, fl, $urandom);
      end else begin
        do_inst("r_invalid", 1'b0, 1'b1, 1'b0, 3'b010, $urandom, $urandom, 1, -1, 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
